deskew_collector: RTL

//  Output-side counterpart of the input skew crossbar. Lane j (0-based) of a systolic-array result row

---
 rtl/mm_pkg.sv | 14 +
 rtl/deskew_collector_row_fifo.sv | 63 ++++++
 rtl/deskew_collector.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/mm_pkg.sv
// Shared types and helpers for the deskew collector.
// Flush FSM states and index-width helper.
package mm_pkg;

    typedef enum logic {
        FL_IDLE,
        FL_FLUSH
    } flush_state_e;

    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/deskew_collector_row_fifo.sv
// Small row FIFO with a zeroed head when empty.
// Overflow is sticky until reset.
module row_fifo
    import mm_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             sync_reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             empty,
    output logic             full,
    output logic             overflow
);
    localparam int PW = idx_w(DEPTH);

    logic [PW-1:0]    wr_q, rd_q;
    logic [PW:0]      cnt_q, cnt_d;
    logic             ovf_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    assign empty     = (cnt_q == '0);
    assign full      = (cnt_q == (PW+1)'(DEPTH));
    assign do_pop    = pop & ~empty;
    // A pop frees the slot, so a full FIFO still accepts a same-cycle push.
    assign do_push   = push & (~full | do_pop);
    assign head_data = empty ? '0 : mem_q[rd_q];
    assign overflow  = ovf_q;

    always_comb begin
        cnt_d = cnt_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else if (!sync_reset_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            if (do_push) wr_q <= wr_q + PW'(1);
            if (do_pop)  rd_q <= rd_q + PW'(1);
            cnt_q <= cnt_d;
            if (push & ~do_push) ovf_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= push_data;
    end

endmodule

// File: rtl/deskew_collector.sv
// Realigns skewed systolic-array result lanes into rows,
// buffers them in a FIFO and drains in-flight rows on flush.
module deskew_collector
    import mm_pkg::*;
#(
    parameter int DATA_WIDTH      = 8,
    parameter int ARRAY_ELLEMENTS = 4,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic                                 clk,
    input  logic                                 reset_n,
    input  logic                                 sync_reset_n,
    input  logic                                 shift,
    input  logic                                 row_valid_i,
    input  logic [ARRAY_ELLEMENTS*DATA_WIDTH-1:0] data_i,
    input  logic                                 flush,
    output logic [ARRAY_ELLEMENTS*DATA_WIDTH-1:0] data_o,
    output logic                                 valid_o,
    input  logic                                 ready_i,
    output logic                                 full_o,
    output logic                                 busy_o,
    output logic                                 done_o,
    output logic                                 overflow_o
);
    localparam int N  = ARRAY_ELLEMENTS;
    localparam int W  = DATA_WIDTH;
    localparam int CW = idx_w(N);

    flush_state_e   state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           done_q, done_d;
    logic           eff_shift, eff_valid;
    logic [N*W-1:0] eff_data, aligned;
    logic           aligned_valid;
    logic           empty;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        done_d    = 1'b0;
        eff_shift = shift;
        eff_valid = row_valid_i;
        eff_data  = data_i;
        unique case (state_q)
            FL_IDLE: begin
                if (flush) begin
                    if (N == 1) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = FL_FLUSH;
                        cnt_d   = CW'(N - 1);
                    end
                end
            end
            FL_FLUSH: begin
                // Self-clock the lines with zeros until the tail row lands.
                eff_shift = 1'b1;
                eff_valid = 1'b0;
                eff_data  = '0;
                cnt_d     = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = FL_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = FL_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= FL_IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else if (!sync_reset_n) begin
            state_q <= FL_IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    for (genvar j = 0; j < N; j++) begin : g_lane
        localparam int D = N - 1 - j;
        if (D == 0) begin : g_pass
            assign aligned[j*W +: W] = eff_data[j*W +: W];
        end else begin : g_dly
            logic [W-1:0] line_q [D];
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    for (int k = 0; k < D; k++) line_q[k] <= '0;
                end else if (!sync_reset_n) begin
                    for (int k = 0; k < D; k++) line_q[k] <= '0;
                end else if (eff_shift) begin
                    line_q[0] <= eff_data[j*W +: W];
                    for (int k = 1; k < D; k++) line_q[k] <= line_q[k-1];
                end
            end
            assign aligned[j*W +: W] = line_q[D-1];
        end
    end

    if (N == 1) begin : g_vnone
        assign aligned_valid = eff_valid;
    end else begin : g_vpipe
        logic [N-2:0] vpipe_q;
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                vpipe_q <= '0;
            end else if (!sync_reset_n) begin
                vpipe_q <= '0;
            end else if (eff_shift) begin
                vpipe_q[0] <= eff_valid;
                for (int k = 1; k < N - 1; k++) vpipe_q[k] <= vpipe_q[k-1];
            end
        end
        assign aligned_valid = vpipe_q[N-2];
    end

    row_fifo #(
        .WIDTH (N*W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk          (clk),
        .reset_n      (reset_n),
        .sync_reset_n (sync_reset_n),
        .push         (eff_shift & aligned_valid),
        .push_data    (aligned),
        .pop          (valid_o & ready_i),
        .head_data    (data_o),
        .empty        (empty),
        .full         (full_o),
        .overflow     (overflow_o)
    );

    assign valid_o = ~empty;
    assign busy_o  = (state_q == FL_FLUSH);
    assign done_o  = done_q;

endmodule
